// File: rtl/stream_fifo_pkg.sv
// Shared width helpers for the stream FIFO: pointer width and occupancy
// counter width, both derived from the storage depth.
package stream_fifo_pkg;

  // Pointer width: enough bits to index DEPTH entries, never less than one.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: must represent every value from 0 up to and including DEPTH.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Bundle of all stream FIFO signals except clock and reset.
//
// Handshake: a word moves across a side on a rising clk edge where both its
// valid and ready are high (and flush is low). The FIFO derives in_ready and
// out_valid from registered state only, so neither depends combinationally on
// in_valid or out_ready. A producer raising valid must not wait for ready and
// holds its data until the transfer happens; the FIFO's out_valid/out_data stay
// stable until popped or flushed.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6
);
  localparam int CW = stream_fifo_pkg::count_width(DEPTH);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;

  // User side: feeds data in, drains data out, controls flush.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full, almost_empty, overflow
  );

  // FIFO side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full, almost_empty, overflow
  );

endinterface

// File: rtl/stream_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port, one
// asynchronous read port, no reset (contents are meaningless until written).
module stream_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6,
  parameter int AW         = stream_fifo_pkg::ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming word into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head word is visible combinationally for first-word-fall-through.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through stream FIFO with arbitrary depth,
// occupancy count, registered almost-full/almost-empty flags, synchronous
// flush and a sticky overflow flag for words offered during a flush.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 6,
  parameter int AFULL_THRES  = DEPTH - 2,
  parameter int AEMPTY_THRES = 1
) (
  input logic          clk,
  input logic          rst,
  stream_fifo_if.slave bus
);

  localparam int              PW           = ptr_width(DEPTH);
  localparam int              CW           = count_width(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR     = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_COUNT   = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_LEVEL  = CW'(AFULL_THRES);
  localparam logic [CW-1:0]   AEMPTY_LEVEL = CW'(AEMPTY_THRES);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          afull_q;
  logic          aempty_q;
  logic          overflow_q;
  logic          push;
  logic          pop;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign bus.in_ready     = (count_q != FULL_COUNT);
  assign bus.out_valid    = (count_q != '0);
  assign bus.count        = count_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = overflow_q;

  // A flush cycle suppresses both transfers.
  assign push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  // Next occupancy; the flags are derived from it so they line up with count.
  always_comb begin
    count_next = count_q;
    if (bus.flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CW'(1);
    end
  end

  // Pointer, occupancy, flag and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) begin
          wptr <= advance(wptr);
        end
        if (pop) begin
          rptr <= advance(rptr);
        end
      end
      count_q  <= count_next;
      afull_q  <= (count_next >= AFULL_LEVEL);
      aempty_q <= (count_next <= AEMPTY_LEVEL);
      if (bus.flush && bus.in_valid) begin
        overflow_q <= 1'b1;
      end
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wptr),
    .wdata (bus.in_data),
    .raddr (rptr),
    .rdata (bus.out_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: directed scenarios on a DEPTH=6 instance and a long
// randomized run on a DEPTH=5 instance, each checked by a queue-based model
// plus an independent output monitor.
module tb_stream_fifo;

  localparam int DW  = 8;
  localparam int D6  = 6;
  localparam int AF6 = 4;
  localparam int AE6 = 1;
  localparam int D5  = 5;
  localparam int AF5 = 4;
  localparam int AE5 = 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst6 = 1'b1;
  logic rst5 = 1'b1;
  always #5 clk = ~clk;

  stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(D6)) bus6 ();
  stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(D5)) bus5 ();

  stream_fifo #(
    .DATA_WIDTH(DW), .DEPTH(D6), .AFULL_THRES(AF6), .AEMPTY_THRES(AE6)
  ) u_dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (bus6)
  );

  stream_fifo #(
    .DATA_WIDTH(DW), .DEPTH(D5), .AFULL_THRES(AF5), .AEMPTY_THRES(AE5)
  ) u_dut5 (
    .clk (clk),
    .rst (rst5),
    .bus (bus5)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp6_q[$];
  logic [DW-1:0] exp5_q[$];
  bit ovf6 = 1'b0;
  bit ovf5 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every status output against the model occupancy.
  task automatic status6();
    int n;
    n = exp6_q.size();
    check("count6", 32'(bus6.count), n);
    check("in_ready6", 32'(bus6.in_ready), 32'(n != D6));
    check("out_valid6", 32'(bus6.out_valid), 32'(n != 0));
    check("almost_full6", 32'(bus6.almost_full), 32'(n >= AF6));
    check("almost_empty6", 32'(bus6.almost_empty), 32'(n <= AE6));
    check("overflow6", 32'(bus6.overflow), 32'(ovf6));
    if (n != 0) check("head6", 32'(bus6.out_data), 32'(exp6_q[0]));
  endtask

  task automatic status5();
    int n;
    n = exp5_q.size();
    check("count5", 32'(bus5.count), n);
    check("in_ready5", 32'(bus5.in_ready), 32'(n != D5));
    check("out_valid5", 32'(bus5.out_valid), 32'(n != 0));
    check("almost_full5", 32'(bus5.almost_full), 32'(n >= AF5));
    check("almost_empty5", 32'(bus5.almost_empty), 32'(n <= AE5));
    check("overflow5", 32'(bus5.overflow), 32'(ovf5));
    if (n != 0) check("head5", 32'(bus5.out_data), 32'(exp5_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: check state left by the previous edge, drive new inputs, and
  // queue the word the model says will be accepted at the coming edge.
  task automatic step6(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit rs);
    @(negedge clk);
    status6();
    bus6.in_valid  = v;
    bus6.in_data   = d;
    bus6.out_ready = r;
    bus6.flush     = f;
    rst6           = rs;
    if (rs) begin
      exp6_q.delete();
      ovf6 = 1'b0;
    end else if (f) begin
      exp6_q.delete();
      if (v) ovf6 = 1'b1;
    end else if (v && exp6_q.size() != D6) begin
      exp6_q.push_back(d);
    end
  endtask

  task automatic step5(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit rs);
    @(negedge clk);
    status5();
    bus5.in_valid  = v;
    bus5.in_data   = d;
    bus5.out_ready = r;
    bus5.flush     = f;
    rst5           = rs;
    if (rs) begin
      exp5_q.delete();
      ovf5 = 1'b0;
    end else if (f) begin
      exp5_q.delete();
      if (v) ovf5 = 1'b1;
    end else if (v && exp5_q.size() != D5) begin
      exp5_q.push_back(d);
    end
  endtask

  // ---------------- monitors ----------------
  // Each accepted output word must be the oldest outstanding expected word.
  always begin
    @(negedge clk);
    #2;
    if (bus6.out_valid === 1'b1 && bus6.out_ready === 1'b1 && bus6.flush !== 1'b1 && rst6 === 1'b0) begin
      if (exp6_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop6: got %0h expected nothing (model empty) at t=%0t", bus6.out_data, $time);
      end else begin
        check("pop6", 32'(bus6.out_data), 32'(exp6_q.pop_front()));
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (bus5.out_valid === 1'b1 && bus5.out_ready === 1'b1 && bus5.flush !== 1'b1 && rst5 === 1'b0) begin
      if (exp5_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop5: got %0h expected nothing (model empty) at t=%0t", bus5.out_data, $time);
      end else begin
        check("pop5", 32'(bus5.out_data), 32'(exp5_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    bit v, r, f, rs;
    int vb;

    bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.out_ready = 1'b0; bus6.flush = 1'b0;
    bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.out_ready = 1'b0; bus5.flush = 1'b0;

    // Reset, then idle; first status check sees the reset values.
    step6(0, 8'h00, 0, 0, 1);
    step6(0, 8'h00, 0, 0, 0);

    // Single word: visible one cycle after push, then drained.
    step6(1, 8'hA5, 0, 0, 0);
    step6(0, 8'h00, 0, 0, 0);
    step6(0, 8'h00, 1, 0, 0);

    // Fill to full, offer one more, then drain in order.
    for (int i = 1; i <= 6; i++) step6(1, 8'(i), 0, 0, 0);
    step6(1, 8'h07, 0, 0, 0);
    for (int i = 0; i < 6; i++) step6(0, 8'h00, 1, 0, 0);

    // Sustained push+pop at occupancy 3.
    d = 8'h10;
    for (int i = 0; i < 3; i++) begin step6(1, d, 0, 0, 0); d++; end
    for (int i = 0; i < 20; i++) begin step6(1, d, 1, 0, 0); d++; end

    // Refill to full, then push+pop together while full.
    for (int i = 0; i < 3; i++) begin step6(1, d, 0, 0, 0); d++; end
    step6(1, 8'hEE, 1, 0, 0);
    step6(0, 8'h00, 1, 0, 0);

    // Flush at occupancy 4 with a word offered: dropped, overflow set.
    step6(1, 8'h77, 0, 1, 0);
    step6(1, 8'h3C, 0, 0, 0);
    step6(1, 8'h3D, 0, 0, 0);
    for (int i = 0; i < 3; i++) step6(0, 8'h00, 1, 0, 0);
    step6(0, 8'h00, 0, 0, 0);

    // Randomized run on the depth-5 instance with alternating fill/drain bias.
    for (int c = 0; c < 10000; c++) begin
      vb = (((c / 400) % 2) == 0) ? 80 : 30;
      v  = ($urandom_range(99) < vb);
      r  = ($urandom_range(99) < (110 - vb));
      f  = ($urandom_range(199) == 0);
      d  = 8'($urandom_range(255));
      rs = (c >= 5000 && c < 5002);
      if (c == 4998) begin f = 1'b1; v = 1'b1; end
      step5(v, d, r, f, rs);
    end
    for (int i = 0; i < 8; i++) step5(0, 8'h00, 1, 0, 0);
    step5(0, 8'h00, 0, 0, 0);
    step6(0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
